// File: rtl/alu_pkg.sv
// Opcode encoding and FSM state type shared by the multi-cycle ALU.
// Build with ALU_MULDIV_EN defined to add the MUL/DIV engine states.
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
    localparam logic [OP_W-1:0] OP_NOT  = 4'b0010;
    localparam logic [OP_W-1:0] OP_SHL  = 4'b0011;
    localparam logic [OP_W-1:0] OP_SHR  = 4'b0100;
    localparam logic [OP_W-1:0] OP_AND  = 4'b0101;
    localparam logic [OP_W-1:0] OP_OR   = 4'b0110;
    localparam logic [OP_W-1:0] OP_SLT  = 4'b0111;
    localparam logic [OP_W-1:0] OP_MUL  = 4'b1100;
    localparam logic [OP_W-1:0] OP_MULH = 4'b1101;
    localparam logic [OP_W-1:0] OP_DIV  = 4'b1110;
    localparam logic [OP_W-1:0] OP_REM  = 4'b1111;

`ifdef ALU_MULDIV_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DONE = 2'd1,
        ST_MUL  = 2'd2,
        ST_DIV  = 2'd3
    } state_e;
`else
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } state_e;
`endif

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle over WIDTH cycles.
// hi/lo present the result of the current step so the final step can be captured as done rises.
module alu_iter_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             is_div_q, is_div_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, b_d;
    logic [WIDTH-1:0] step_hi, step_lo, div_diff;
    logic [WIDTH:0]   mul_sum, div_trial;
    logic             div_ge, last;

    assign last = (cnt_q == CW'(WIDTH - 1));

    always_comb begin
        // Multiply: hi:lo holds partial product : remaining multiplier bits.
        // Divide:   hi:lo holds partial remainder : dividend bits becoming quotient bits.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        div_trial = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_trial >= {1'b0, b_q});
        div_diff  = div_trial[WIDTH-1:0] - b_q;

        if (is_div_q) begin
            step_hi = div_ge ? div_diff : div_trial[WIDTH-1:0];
            step_lo = {lo_q[WIDTH-2:0], div_ge};
        end else begin
            step_hi = mul_sum[WIDTH:1];
            step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end

        busy_d   = busy_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        is_div_d = is_div_q;

        if (start) begin
            busy_d   = 1'b1;
            cnt_d    = '0;
            hi_d     = '0;
            lo_d     = a;
            b_d      = b;
            is_div_d = is_div;
        end else if (busy_q) begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            is_div_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            is_div_q <= is_div_d;
        end
    end

    assign busy = busy_q;
    assign done = busy_q & last;
    assign hi   = step_hi;
    assign lo   = step_lo;

endmodule

// File: rtl/alu_multicycle.sv
// EX-stage ALU with valid/ready handshake, one operation in flight, registered result and flags.
// Define ALU_MULDIV_EN to build the iterative MUL/DIV engine; otherwise opcodes 1100-1111 are illegal.
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = OP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CNT_W-1:0] op,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             div_by_zero,
    output logic             illegal_op
);

    localparam int               SH_W    = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             dbz_q, dbz_d;
    logic             ill_q, ill_d;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             div_zero;

`ifdef ALU_MULDIV_EN
    logic             hi_sel_q, hi_sel_d;
    logic             is_muldiv, eng_start, eng_busy, eng_done;
    logic [WIDTH-1:0] eng_hi, eng_lo, eng_res;

    assign is_muldiv = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    assign div_zero  = ((op == OP_DIV) || (op == OP_REM)) && (in2 == '0);
    assign eng_start = in_valid && in_ready && is_muldiv && !div_zero;
    assign eng_res   = hi_sel_q ? eng_hi : eng_lo;

    alu_iter_muldiv #(.WIDTH(WIDTH)) u_engine (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (eng_start),
        .is_div (op[1]),
        .a      (in1),
        .b      (in2),
        .busy   (eng_busy),
        .done   (eng_done),
        .hi     (eng_hi),
        .lo     (eng_lo)
    );

    engine_busy_a: assert property (@(posedge clk) disable iff (!rst_n)
        (state_q == ST_MUL || state_q == ST_DIV) |-> eng_busy);
`else
    assign div_zero = 1'b0;
`endif

    always_comb begin
        // NOTE: every combinational output is defaulted first so no path leaves it unassigned (no latch).
        alu_res = '0;
        alu_ill = 1'b0;
        case (op)
            OP_ADD:  alu_res = in1 + in2;
            OP_SUB:  alu_res = in1 - in2;
            OP_NOT:  alu_res = ~in1;
            OP_SHL:  alu_res = (in2 >= WIDTH_V) ? '0 : (in1 << in2[SH_W-1:0]);
            OP_SHR:  alu_res = (in2 >= WIDTH_V) ? '0 : (in1 >> in2[SH_W-1:0]);
            OP_AND:  alu_res = in1 & in2;
            OP_OR:   alu_res = in1 | in2;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, (in1 < in2)};
`ifdef ALU_MULDIV_EN
            // Only reached as a 1-cycle result when the divisor is zero.
            OP_DIV:  alu_res = '1;
            OP_REM:  alu_res = in1;
            OP_MUL,
            OP_MULH: alu_res = '0;
`endif
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        ill_d    = ill_q;
`ifdef ALU_MULDIV_EN
        hi_sel_d = hi_sel_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
`ifdef ALU_MULDIV_EN
                    if (eng_start) begin
                        state_d  = op[1] ? ST_DIV : ST_MUL;
                        hi_sel_d = op[0];
                    end else
`endif
                    begin
                        state_d  = ST_DONE;
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        dbz_d    = div_zero;
                        ill_d    = alu_ill;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            ST_MUL, ST_DIV: begin
                if (eng_done) begin
                    state_d  = ST_DONE;
                    result_d = eng_res;
                    zero_d   = (eng_res == '0);
                    dbz_d    = 1'b0;
                    ill_d    = 1'b0;
                end
            end
`endif
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state uses non-blocking assignments so every flop updates from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
            ill_q    <= 1'b0;
`ifdef ALU_MULDIV_EN
            hi_sel_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
            ill_q    <= ill_d;
`ifdef ALU_MULDIV_EN
            hi_sel_q <= hi_sel_d;
`endif
        end
    end

    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = (state_q == ST_DONE);
    assign result      = result_q;
    assign zero        = zero_q;
    assign div_by_zero = dbz_q;
    assign illegal_op  = ill_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle; expectations follow ALU_MULDIV_EN (MUL/DIV become illegal without it).
`timescale 1ns/1ps
module tb_alu_multicycle;
    import alu_pkg::*;

`ifdef ALU_MULDIV_EN
    localparam bit MD = 1'b1;
`else
    localparam bit MD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, out_valid, out_ready;
    logic        zero, div_by_zero, illegal_op;
    logic [3:0]  op;
    logic [15:0] in1, in2, result;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
        logic        dbz;
        logic        ill;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    alu_multicycle #(.WIDTH(16), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .op          (op),
        .in1         (in1),
        .in2         (in2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .div_by_zero (div_by_zero),
        .illegal_op  (illegal_op)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] res, input logic dbz, input logic ill, input int lat);
        vec_t v;
        v.op  = o;
        v.a   = a;
        v.b   = b;
        v.res = res;
        v.z   = (res == 16'h0000);
        v.dbz = dbz;
        v.ill = ill;
        v.lat = lat;
        return v;
    endfunction

    // MUL/DIV vector: real result when the engine is built, illegal 1-cycle otherwise.
    function automatic vec_t md(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                                input logic [15:0] res, input logic dbz, input int lat);
        if (MD) return mk(o, a, b, res, dbz, 1'b0, lat);
        return mk(o, a, b, 16'h0000, 1'b0, 1'b1, 1);
    endfunction

    task automatic run_op(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b,
                          output logic [15:0] r, output logic z, output logic d, output logic i,
                          output int lat);
        @(negedge clk);
        check("in_ready before issue", {31'b0, in_ready}, 32'd1);
        op       = o;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        op       = ~o;
        in1      = ~a;
        in2      = b + 16'h0003;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        r = result;
        z = zero;
        d = div_by_zero;
        i = illegal_op;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [15:0] r;
        logic        z, d, i;
        int          lat;

        vecs.push_back(mk(OP_ADD, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SUB, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SHL, 16'h0001, 16'd16,   16'h0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SLT, 16'h0003, 16'h0009, 16'h0001, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SLT, 16'h0009, 16'h0003, 16'h0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SLT, 16'h0007, 16'h0007, 16'h0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_NOT, 16'h00FF, 16'h1234, 16'hFF00, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SHR, 16'h8000, 16'd15,   16'h0001, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SHR, 16'h8000, 16'h0100, 16'h0000, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SHL, 16'h0001, 16'd15,   16'h8000, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_AND, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_OR,  16'hF0F0, 16'h0F00, 16'hFFF0, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_SUB, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 1));
        vecs.push_back(mk(OP_ADD, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 1));
        vecs.push_back(md(OP_MUL,  16'h1234, 16'h0100, 16'h3400, 1'b0, 17));
        vecs.push_back(md(OP_MULH, 16'h1234, 16'h0100, 16'h0012, 1'b0, 17));
        vecs.push_back(md(OP_MUL,  16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 17));
        vecs.push_back(md(OP_MULH, 16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b0, 17));
        vecs.push_back(md(OP_DIV,  16'd100,  16'd7,    16'h000E, 1'b0, 17));
        vecs.push_back(md(OP_REM,  16'd100,  16'd7,    16'h0002, 1'b0, 17));
        vecs.push_back(md(OP_DIV,  16'd9,    16'd0,    16'hFFFF, 1'b1, 1));
        vecs.push_back(md(OP_REM,  16'd9,    16'd0,    16'h0009, 1'b1, 1));
        vecs.push_back(md(OP_DIV,  16'hFFFF, 16'h0001, 16'hFFFF, 1'b0, 17));
        vecs.push_back(md(OP_REM,  16'h0000, 16'h0005, 16'h0000, 1'b0, 17));
        vecs.push_back(mk(4'b1000, 16'h0001, 16'h0002, 16'h0000, 1'b0, 1'b1, 1));
        vecs.push_back(mk(4'b1011, 16'hAAAA, 16'h5555, 16'h0000, 1'b0, 1'b1, 1));

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op        = 4'h0;
        in1       = 16'h0;
        in2       = 16'h0;
        #12;
        check("reset in_ready",    {31'b0, in_ready},    32'd1);
        check("reset out_valid",   {31'b0, out_valid},   32'd0);
        check("reset result",      {16'b0, result},      32'd0);
        check("reset zero",        {31'b0, zero},        32'd0);
        check("reset div_by_zero", {31'b0, div_by_zero}, 32'd0);
        check("reset illegal_op",  {31'b0, illegal_op},  32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[k]) begin
            run_op(vecs[k].op, vecs[k].a, vecs[k].b, r, z, d, i, lat);
            check($sformatf("v%0d op%0h result", k, vecs[k].op), {16'b0, r}, {16'b0, vecs[k].res});
            check($sformatf("v%0d zero", k),        {31'b0, z}, {31'b0, vecs[k].z});
            check($sformatf("v%0d div_by_zero", k), {31'b0, d}, {31'b0, vecs[k].dbz});
            check($sformatf("v%0d illegal_op", k),  {31'b0, i}, {31'b0, vecs[k].ill});
            check($sformatf("v%0d latency", k),     lat,        vecs[k].lat);
        end

        // Result held while out_ready stays low; a waiting in_valid is not accepted, even on delivery.
        @(negedge clk);
        op       = OP_ADD;
        in1      = 16'd2;
        in2      = 16'd3;
        in_valid = 1'b1;
        @(negedge clk);
        check("hold out_valid", {31'b0, out_valid}, 32'd1);
        op  = OP_SUB;
        in1 = 16'h0100;
        in2 = 16'h0001;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("hold c%0d result", c),    {16'b0, result},    32'd5);
            check($sformatf("hold c%0d in_ready", c),  {31'b0, in_ready},  32'd0);
            check($sformatf("hold c%0d out_valid", c), {31'b0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("after delivery out_valid", {31'b0, out_valid}, 32'd0);
        check("after delivery in_ready",  {31'b0, in_ready},  32'd1);
        in_valid = 1'b0;

        // Reset in the middle of a multiply aborts it.
        @(negedge clk);
        op       = OP_MUL;
        in1      = 16'h1234;
        in2      = 16'h0100;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (7) @(negedge clk);
        check("mid-mul out_valid", {31'b0, out_valid}, MD ? 32'd0 : 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort out_valid",   {31'b0, out_valid},   32'd0);
        check("abort in_ready",    {31'b0, in_ready},    32'd1);
        check("abort result",      {16'b0, result},      32'd0);
        check("abort zero",        {31'b0, zero},        32'd0);
        check("abort illegal_op",  {31'b0, illegal_op},  32'd0);
        check("abort div_by_zero", {31'b0, div_by_zero}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("post-abort out_valid", {31'b0, out_valid}, 32'd0);

        run_op(4'b1000, 16'h0003, 16'h0004, r, z, d, i, lat);
        check("post-abort illegal result", {16'b0, r}, 32'd0);
        check("post-abort illegal zero",   {31'b0, z}, 32'd1);
        check("post-abort illegal flag",   {31'b0, i}, 32'd1);
        check("post-abort illegal lat",    lat,        32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
